// File: rtl/bp_table_port_sched.sv
// Arbitrates one single-port predictor table between fetch lookups and queued retire updates,
// forwarding pending update data to lookups and sweeping INIT_VAL after reset or ClearReq.
module bp_table_port_sched #(
  parameter int IDX_W    = 10,
  parameter int DATA_W   = 2,
  parameter int INIT_VAL = 1,
  parameter int FIFO_D   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ClearReq,
  input  logic              LookupValidF,
  input  logic [IDX_W-1:0]  LookupIdxF,
  output logic              LookupGrantF,
  output logic [DATA_W-1:0] LookupDataF,
  output logic              LookupDataValidF,
  input  logic              UpdValidM,
  input  logic [IDX_W-1:0]  UpdIdxM,
  input  logic [DATA_W-1:0] UpdDataM,
  output logic              UpdReadyM,
  output logic              Busy,
  output logic              TblEn,
  output logic              TblWe,
  output logic [IDX_W-1:0]  TblIdx,
  output logic [DATA_W-1:0] TblWData,
  input  logic [DATA_W-1:0] TblRData
);

  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   sweepPtr;
  logic [IDX_W-1:0]   fifoIdx  [FIFO_D];
  logic [DATA_W-1:0]  fifoData [FIFO_D];
  logic [PTR_W-1:0]   rdPtr, wrPtr, slot;
  logic [CNT_W-1:0]   count;
  logic [WAIT_W-1:0]  waitCnt;
  logic               full, empty, active, doWrite, doRead, push;
  logic               fwdHit, fwdHitQ, dataValidQ;
  logic [DATA_W-1:0]  fwdData, fwdDataQ;

  always_comb begin
    full    = (count == CNT_W'(FIFO_D));
    empty   = (count == '0);
    // The ClearReq cycle issues no table op so nothing stale can land before the sweep
    active  = ~reset & ~ClearReq;
    doWrite = active & (state == RUN) & ~empty &
              (full | (waitCnt == WAIT_W'(MAX_WAIT)) | ~LookupValidF);
    doRead  = active & (state == RUN) & ~doWrite & LookupValidF;
    push    = active & UpdValidM & ~full;
  end

  always_comb begin
    TblEn    = 1'b0;
    TblWe    = 1'b0;
    TblIdx   = '0;
    TblWData = '0;
    if (active && state == SWEEP) begin
      TblEn    = 1'b1;
      TblWe    = 1'b1;
      TblIdx   = sweepPtr;
      TblWData = DATA_W'(INIT_VAL);
    end else if (doWrite) begin
      TblEn    = 1'b1;
      TblWe    = 1'b1;
      TblIdx   = fifoIdx[rdPtr];
      TblWData = fifoData[rdPtr];
    end else if (doRead) begin
      TblEn    = 1'b1;
      TblIdx   = LookupIdxF;
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    slot    = '0;
    for (int unsigned k = 0; k < FIFO_D; k++) begin
      slot = rdPtr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (fifoIdx[slot] == LookupIdxF)) begin
        fwdHit  = 1'b1;
        fwdData = fifoData[slot];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoIdx[wrPtr]  <= UpdIdxM;
      fifoData[wrPtr] <= UpdDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SWEEP;
      sweepPtr   <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      waitCnt    <= '0;
      dataValidQ <= 1'b0;
      fwdHitQ    <= 1'b0;
      fwdDataQ   <= '0;
    end else begin
      dataValidQ <= doRead;
      if (doRead) begin
        fwdHitQ  <= fwdHit;
        fwdDataQ <= fwdData;
      end
      if (ClearReq) begin
        state    <= SWEEP;
        sweepPtr <= '0;
        rdPtr    <= '0;
        wrPtr    <= '0;
        count    <= '0;
        waitCnt  <= '0;
      end else begin
        case (state)
          SWEEP: begin
            sweepPtr <= sweepPtr + 1'b1;
            if (sweepPtr == '1) state <= RUN;
          end
          RUN:     ;
          default: state <= SWEEP;
        endcase
        if (push)    wrPtr <= wrPtr + 1'b1;
        if (doWrite) rdPtr <= rdPtr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(doWrite);
        if (doWrite || empty)
          waitCnt <= '0;
        else if (waitCnt != WAIT_W'(MAX_WAIT))
          waitCnt <= waitCnt + 1'b1;
      end
    end
  end

  assign LookupGrantF     = doRead;
  assign LookupDataValidF = dataValidQ;
  assign LookupDataF      = dataValidQ ? (fwdHitQ ? fwdDataQ : TblRData) : '0;
  assign UpdReadyM        = ~full;
  assign Busy             = (state == SWEEP);

endmodule
